fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the instruction-fetch stage. It owns the PC and issues requests to the instruction memory over a req/ack handshake. It buffers each returned word into a valid-qualified IF/ID output register and holds that register under back-pressure with a one-entry skid buffer. On a taken branch it flushes in-flight and buffered fetches. It sits between the execute-stage branch resolution and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset.
PC_W, 32, width of PC, addresses and instruction words.

Ports:
clk  in  1  clock; all state updates on rising edge only.
rst  in  1  synchronous, active-high reset.
branch_taken  in  1  redirect request, sampled every cycle.
branch_target  in  PC_W  redirect address, valid with branch_taken.
stall  in  1  decode cannot accept; output register must hold.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  PC_W  request address; stable while imem_req=1 and imem_ack=0.
imem_ack  in  1  response valid this cycle; may coincide with imem_req's first cycle (zero-wait memory).
imem_rdata  in  PC_W  instruction word, valid with imem_ack.
if_valid  out  1  if_instr/if_pc hold a live instruction.
if_instr  out  PC_W  fetched instruction.
if_pc  out  PC_W  address of if_instr.
if_pc_pl4  out  PC_W  if_pc + 4, modulo 2^PC_W.
fetch_fault  out  1  sticky misaligned-branch fault.

Behaviour:
- Reset: rst (clk = clk, rst = rst, synchronous, active-high) sets FSM=S_RESET and pc=RESET_PC. It clears req_addr, the drop flag and the skid buffer. All outputs go to 0, except if_pc_pl4, which is 4. Reset asserted in any state, mid-handshake included, aborts everything. A pending memory response after reset is a memory-side concern; the block ignores ack while in S_RESET.
- S_RESET: imem_req=0. Moves to S_FETCH on the first cycle with rst=0. First request is at RESET_PC one cycle after rst deasserts.
- S_FETCH: imem_req=1, imem_addr=req_addr.
  - Output "free" means if_valid=0, or if_valid=1 and stall=0 (consumed this cycle).
  - On ack with no drop and no branch, if output is free: next cycle the output register takes (imem_rdata, req_addr), if_valid=1 and req_addr advances by 4. This gives 1 instruction/cycle with a zero-wait memory; latency is ack to if_valid in 1 cycle.
  - On ack with no drop and no branch, if output is not free: the word and address go to the skid buffer, FSM moves to S_HOLD, and imem_req drops next cycle.
- S_HOLD: imem_req=0. When the output is consumed (stall=0), the skid entry moves to the output register, req_addr advances by 4, and FSM returns to S_FETCH.
- Consumption without refill: if_valid clears the cycle after an if_valid=1, stall=0 cycle when nothing new is loaded.
- Branch, highest priority over stall and ack:
  - if_valid and the skid buffer clear next cycle.
  - Target aligned (branch_target[1:0]==0), same cycle as ack or no request outstanding (S_HOLD): response discarded; req_addr=target; S_FETCH next cycle.
  - Target aligned, in S_FETCH with imem_req=1 and no ack: imem_addr must stay stable, so set drop=1 and latch pending target. At the ack, discard the word, clear drop, set imem_req=0 for one cycle, then request the target.
  - A second branch while drop=1 overwrites the pending target.
  - Target misaligned: go to S_FAULT. fetch_fault=1, imem_req=0 (after any outstanding ack, which is discarded), if_valid=0. Held until rst.
- Arithmetic: all PC additions wrap modulo 2^PC_W; 32'hFFFF_FFFC + 4 = 0.
- Stall while if_valid=0 has no effect.

Optional Feature:
FETCH_PERF_EN. When defined, adds output ports perf_fetched[31:0] (increments per instruction loaded into the output register) and perf_flushed[31:0] (increments per discarded response or skid entry). Both counters clear on rst and wrap. When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset released at cycle 0 with ack tied to req: imem_addr = 0,4,8 on cycles 1,2,3; if_valid=1 on cycles 2,3,4 with if_pc = 0,4,8 and if_pc_pl4 = 4,8,12.
2. stall=1 for 3 cycles while streaming: if_instr held at pc 0x8; word 0xC goes to the skid buffer and imem_req=0; after stall drops, if_pc=0xC follows 0x8 with no gap or loss.
3. Memory ack delayed 3 cycles; branch_taken at cycle 1 with target 0x100: imem_addr held at the old value until ack; that word is discarded; imem_req low one cycle; next request at 0x100; if_valid never shows the old word.
4. Branch in S_HOLD to 0x40: skid and output cleared next cycle; next request at 0x40.
5. branch_target=0x102: fetch_fault=1 and imem_req=0 until rst, which restores a fetch from RESET_PC.
6. PC starting at 0xFFFF_FFFC (via branch): next request address is 0x0; if_pc_pl4 of that instruction is 0x0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack handshake and
// feeds decode through a valid-qualified output register with a one-entry skid buffer.
// Optional: define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            if_valid,
  output logic [PC_W-1:0] if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_pc_pl4,
  output logic            fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_GAP,
    S_FAULT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] req_addr;
  logic            drop;
  logic            pend_fault;
  logic [PC_W-1:0] pend_target;
  logic            skid_valid;
  logic [PC_W-1:0] skid_instr;
  logic [PC_W-1:0] skid_pc;

  logic out_free;
  logic consume;
  logic br_aligned;
  logic load_fetch;
  logic load_skid;
  logic flush_evt;

  assign imem_addr = req_addr;

  // Output register can take a new word when empty or being consumed this cycle.
  always_comb begin
    out_free   = !if_valid || !stall;
    consume    = if_valid && !stall;
    br_aligned = (branch_target[1:0] == 2'b00);
    load_fetch = (state == S_FETCH) && imem_ack && !branch_taken && !drop && out_free;
    load_skid  = (state == S_HOLD) && !branch_taken && out_free;
    flush_evt  = ((state == S_FETCH) && imem_ack && (branch_taken || drop)) ||
                 ((state == S_HOLD) && branch_taken && skid_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      req_addr    <= '0;
      imem_req    <= 1'b0;
      drop        <= 1'b0;
      pend_fault  <= 1'b0;
      pend_target <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_pl4   <= PC_STEP;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          req_addr <= RESET_PC;
        end

        S_FETCH: begin
          if (branch_taken) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (imem_ack) begin
              drop       <= 1'b0;
              pend_fault <= 1'b0;
              if (br_aligned) begin
                req_addr <= branch_target;
              end else begin
                state       <= S_FAULT;
                imem_req    <= 1'b0;
                fetch_fault <= 1'b1;
              end
            end else begin
              // Address must stay stable until the ack, so park the redirect.
              drop        <= 1'b1;
              pend_target <= branch_target;
              pend_fault  <= !br_aligned;
            end
          end else if (imem_ack && drop) begin
            drop       <= 1'b0;
            pend_fault <= 1'b0;
            imem_req   <= 1'b0;
            if (pend_fault) begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
              if_valid    <= 1'b0;
            end else begin
              state    <= S_GAP;
              req_addr <= pend_target;
              if (consume) if_valid <= 1'b0;
            end
          end else if (load_fetch) begin
            if_valid  <= 1'b1;
            if_instr  <= imem_rdata;
            if_pc     <= req_addr;
            if_pc_pl4 <= req_addr + PC_STEP;
            req_addr  <= req_addr + PC_STEP;
          end else if (imem_ack) begin
            skid_valid <= 1'b1;
            skid_instr <= imem_rdata;
            skid_pc    <= req_addr;
            state      <= S_HOLD;
            imem_req   <= 1'b0;
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (br_aligned) begin
              req_addr <= branch_target;
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
            end
          end else if (load_skid) begin
            if_valid   <= 1'b1;
            if_instr   <= skid_instr;
            if_pc      <= skid_pc;
            if_pc_pl4  <= skid_pc + PC_STEP;
            req_addr   <= skid_pc + PC_STEP;
            skid_valid <= 1'b0;
            state      <= S_FETCH;
            imem_req   <= 1'b1;
          end
        end

        S_GAP: begin
          if (branch_taken) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (br_aligned) begin
              req_addr <= branch_target;
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
            end
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            if (consume) if_valid <= 1'b0;
          end
        end

        S_FAULT: begin
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end

        default: begin
          state    <= S_RESET;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Event counters; free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (load_fetch || load_skid) perf_fetched <= perf_fetched + 32'd1;
      if (flush_evt) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_evt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a latency-configurable memory model.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_pl4;
  logic        fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  fetch_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_pl4    (if_pc_pl4),
    .fetch_fault  (fetch_fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers ack_delay cycles after a request is raised; word = addr ^ KEY.
  assign imem_ack   = imem_req && (wait_cnt == ack_delay);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: rst low, next edge starts fetching.
  task automatic do_reset(input int delay);
    ack_delay     = delay;
    rst           = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    stall         = 1'b0;
    tick;
    tick;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pl4", if_pc_pl4, 32'd4);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // 1: zero-wait streaming from reset
    do_reset(0);
    tick;
    check("t1_c1_req", 32'(imem_req), 32'd1);
    check("t1_c1_addr", imem_addr, 32'h0);
    check("t1_c1_valid", 32'(if_valid), 32'd0);
    tick;
    check("t1_c2_addr", imem_addr, 32'h4);
    check("t1_c2_valid", 32'(if_valid), 32'd1);
    check("t1_c2_pc", if_pc, 32'h0);
    check("t1_c2_pl4", if_pc_pl4, 32'h4);
    check("t1_c2_instr", if_instr, 32'h0 ^ KEY);
    tick;
    check("t1_c3_addr", imem_addr, 32'h8);
    check("t1_c3_pc", if_pc, 32'h4);
    check("t1_c3_pl4", if_pc_pl4, 32'h8);
    tick;
    check("t1_c4_addr", imem_addr, 32'hC);
    check("t1_c4_pc", if_pc, 32'h8);
    check("t1_c4_pl4", if_pc_pl4, 32'hC);

    // 2: three-cycle stall while streaming; 0xC parks in the skid buffer
    stall = 1'b1;
    tick;
    check("t2_c5_req", 32'(imem_req), 32'd0);
    check("t2_c5_pc", if_pc, 32'h8);
    check("t2_c5_valid", 32'(if_valid), 32'd1);
    tick;
    check("t2_c6_req", 32'(imem_req), 32'd0);
    check("t2_c6_pc", if_pc, 32'h8);
    check("t2_c6_instr", if_instr, 32'h8 ^ KEY);
    tick;
    stall = 1'b0;
    check("t2_c7_pc", if_pc, 32'h8);
    tick;
    check("t2_c8_pc", if_pc, 32'hC);
    check("t2_c8_instr", if_instr, 32'hC ^ KEY);
    check("t2_c8_valid", 32'(if_valid), 32'd1);
    check("t2_c8_addr", imem_addr, 32'h10);
    tick;
    check("t2_c9_pc", if_pc, 32'h10);

    // 3: branch during a slow request; old word dropped, one idle cycle, then target
    do_reset(3);
    tick;
    check("t3_c1_addr", imem_addr, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick;
    branch_taken = 1'b0;
    check("t3_c2_addr", imem_addr, 32'h0);
    check("t3_c2_req", 32'(imem_req), 32'd1);
    tick;
    check("t3_c3_addr", imem_addr, 32'h0);
    tick;
    check("t3_c4_ack", 32'(imem_ack), 32'd1);
    check("t3_c4_addr", imem_addr, 32'h0);
    tick;
    check("t3_c5_req", 32'(imem_req), 32'd0);
    check("t3_c5_valid", 32'(if_valid), 32'd0);
    for (int c = 6; c <= 9; c++) begin
      tick;
      check("t3_wait_req", 32'(imem_req), 32'd1);
      check("t3_wait_addr", imem_addr, 32'h100);
      check("t3_wait_valid", 32'(if_valid), 32'd0);
    end
    tick;
    check("t3_c10_valid", 32'(if_valid), 32'd1);
    check("t3_c10_pc", if_pc, 32'h100);
    check("t3_c10_instr", if_instr, 32'h100 ^ KEY);

    // 4: branch while holding a skid entry
    do_reset(0);
    tick;
    tick;
    stall = 1'b1;
    check("t4_c2_pc", if_pc, 32'h0);
    tick;
    check("t4_c3_req", 32'(imem_req), 32'd0);
    check("t4_c3_valid", 32'(if_valid), 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick;
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("t4_c4_valid", 32'(if_valid), 32'd0);
    check("t4_c4_req", 32'(imem_req), 32'd1);
    check("t4_c4_addr", imem_addr, 32'h40);
    tick;
    check("t4_c5_pc", if_pc, 32'h40);
    check("t4_c5_instr", if_instr, 32'h40 ^ KEY);
    check("t4_c5_addr", imem_addr, 32'h44);

    // 5: misaligned target faults until reset
    do_reset(0);
    tick;
    tick;
    check("t5_c2_valid", 32'(if_valid), 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h102;
    tick;
    branch_taken = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      check("t5_fault", 32'(fetch_fault), 32'd1);
      check("t5_req", 32'(imem_req), 32'd0);
      check("t5_valid", 32'(if_valid), 32'd0);
      tick;
    end
    rst = 1'b1;
    tick;
    check("t5_rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    tick;
    check("t5_re_req", 32'(imem_req), 32'd1);
    check("t5_re_addr", imem_addr, 32'h0);
    tick;
    check("t5_re_pc", if_pc, 32'h0);
    check("t5_re_valid", 32'(if_valid), 32'd1);

    // 6: PC wraps past the top of the address space; stall with empty output is ignored
    do_reset(0);
    tick;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick;
    branch_taken = 1'b0;
    stall        = 1'b1;
    check("t6_c2_addr", imem_addr, 32'hFFFF_FFFC);
    check("t6_c2_valid", 32'(if_valid), 32'd0);
    tick;
    stall = 1'b0;
    check("t6_c3_pc", if_pc, 32'hFFFF_FFFC);
    check("t6_c3_pl4", if_pc_pl4, 32'h0);
    check("t6_c3_instr", if_instr, 32'hA5A5_FFFC);
    check("t6_c3_addr", imem_addr, 32'h0);
    tick;
    check("t6_c4_pc", if_pc, 32'h0);
    check("t6_c4_pl4", if_pc_pl4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
